// File: rtl/noc_packet_sink_if.sv
// Receive-side flit channel between a router local output port and a sink.
// Fallback widths apply only when the NoC configuration macros are not already set.
`ifndef Noc_Data_Width
`define Noc_Data_Width 32
`endif
`ifndef Noc_Source_Point
`define Noc_Source_Point 8
`endif
`ifndef Noc_ID_X_Width
`define Noc_ID_X_Width 2
`endif
`ifndef Noc_ID_Y_Width
`define Noc_ID_Y_Width 2
`endif

interface noc_packet_sink_if #(
    parameter int DATA_W = `Noc_Data_Width
) ();
    logic              receive_valid;
    logic              receive_ready;
    logic [DATA_W-1:0] receive_flit;
    logic              receive_is_header;
    logic              receive_is_tail;

    modport master (
        output receive_valid, receive_flit, receive_is_header, receive_is_tail,
        input  receive_ready
    );

    modport slave (
        input  receive_valid, receive_flit, receive_is_header, receive_is_tail,
        output receive_ready
    );
endinterface

// File: rtl/noc_packet_sink.sv
// Terminating NoC packet consumer: buffers flits, checks the generator format, keeps statistics.
// Optional NOC_SINK_BACKPRESSURE_EN adds LFSR-driven pop stalls to provoke upstream backpressure.
`ifndef Noc_Data_Width
`define Noc_Data_Width 32
`endif
`ifndef Noc_Source_Point
`define Noc_Source_Point 8
`endif
`ifndef Noc_ID_X_Width
`define Noc_ID_X_Width 2
`endif
`ifndef Noc_ID_Y_Width
`define Noc_ID_Y_Width 2
`endif

module noc_packet_sink #(
    parameter logic [`Noc_ID_X_Width-1:0] X_ID = '0,
    parameter logic [`Noc_ID_Y_Width-1:0] Y_ID = '0,
    parameter int DATA_W     = `Noc_Data_Width,
    parameter int SRC_LSB    = `Noc_Source_Point,
    parameter int EXP_BODY   = 11,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                       noc_clk,
    input  logic                       noc_rst,
    noc_packet_sink_if.slave           rx,
    output logic                       pkt_done,
    output logic [15:0]                pkt_ok_cnt,
    output logic [7:0]                 err_cnt,
    output logic [5:0]                 err_flags,
    output logic [`Noc_ID_X_Width-1:0] last_src_x,
    output logic [`Noc_ID_Y_Width-1:0] last_src_y
);
    localparam int XW  = `Noc_ID_X_Width;
    localparam int YW  = `Noc_ID_Y_Width;
    localparam int IDW = XW + YW;
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int EW  = DATA_W + 2;
    localparam logic [IDW-1:0] OWN_ID = {X_ID, Y_ID};
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BODY = 1'b1;

    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [PW:0]   count_reg;
    logic          full, empty, push, pop, stall;

    assign full             = (count_reg == (PW+1)'(FIFO_DEPTH));
    assign empty            = (count_reg == '0);
    assign rx.receive_ready = !full;
    assign push             = rx.receive_valid && !full;
    assign pop              = !empty && !stall;

`ifdef NOC_SINK_BACKPRESSURE_EN
    // Stall decision comes from a register, so a full-FIFO push+pop never depends on combinational pop.
    logic [15:0] lfsr_reg;
    always_ff @(posedge noc_clk) begin
        if (noc_rst) lfsr_reg <= 16'hACE1;
        else         lfsr_reg <= {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
    end
    assign stall = (lfsr_reg[1:0] == 2'b00);
`else
    assign stall = 1'b0;
`endif

    always_ff @(posedge noc_clk) begin
        if (push) mem[wr_ptr_reg] <= {rx.receive_is_header, rx.receive_is_tail, rx.receive_flit};
    end

    always_ff @(posedge noc_clk) begin
        if (noc_rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_reg + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
        end
    end

    logic [EW-1:0]     head;
    logic [DATA_W-1:0] head_flit;
    logic              head_h, head_t;
    logic [IDW-1:0]    head_src, head_dst;

    assign head      = mem[rd_ptr_reg];
    assign head_h    = head[DATA_W+1];
    assign head_t    = head[DATA_W];
    assign head_flit = head[DATA_W-1:0];
    assign head_src  = head_flit[SRC_LSB +: IDW];
    assign head_dst  = head_flit[SRC_LSB-IDW +: IDW];

    logic [0:0]     state_reg, state_next;
    logic [IDW-1:0] src_reg, src_next, dst_reg, dst_next, last_src_reg, last_src_next;
    logic [7:0]     body_cnt_reg, body_cnt_next;
    logic           bad_reg, bad_next, done_next, ok_inc, len_bad, fld_bad;
    logic [1:0]     err_inc;
    logic [5:0]     flags_set;

    // A header met inside BODY closes the old packet and opens a new one in the same pop;
    // with the tail bit also set that is two completions, so err_inc can reach 2.
    always_comb begin
        state_next    = state_reg;
        src_next      = src_reg;
        dst_next      = dst_reg;
        body_cnt_next = body_cnt_reg;
        bad_next      = bad_reg;
        last_src_next = last_src_reg;
        done_next     = 1'b0;
        ok_inc        = 1'b0;
        err_inc       = 2'd0;
        flags_set     = '0;
        len_bad       = 1'b0;
        fld_bad       = 1'b0;
        if (pop) begin
            if (head_h) begin
                if (state_reg == S_BODY) begin
                    flags_set[2]  = 1'b1;
                    err_inc       = err_inc + 2'd1;
                    done_next     = 1'b1;
                    last_src_next = src_reg;
                end
                src_next      = head_src;
                dst_next      = head_dst;
                body_cnt_next = '0;
                bad_next      = (head_dst != OWN_ID);
                flags_set[1]  = (head_dst != OWN_ID);
                state_next    = S_BODY;
            end else if (state_reg == S_IDLE) begin
                flags_set[0] = 1'b1;
                err_inc      = err_inc + 2'd1;
            end else if (!head_t) begin
                if (head_flit != {DATA_W{1'b1}}) begin
                    flags_set[3] = 1'b1;
                    bad_next     = 1'b1;
                end
                if (body_cnt_reg != 8'hFF) body_cnt_next = body_cnt_reg + 8'd1;
            end
            if (head_t && (head_h || state_reg == S_BODY)) begin
                len_bad      = (body_cnt_next != 8'(EXP_BODY));
                fld_bad      = (head_src != src_next) || (head_dst != dst_next);
                flags_set[4] = len_bad;
                flags_set[5] = fld_bad;
                if (bad_next || len_bad || fld_bad) err_inc = err_inc + 2'd1;
                else                                ok_inc  = 1'b1;
                done_next     = 1'b1;
                last_src_next = src_next;
                state_next    = S_IDLE;
            end
        end
    end

    logic [8:0] err_sum;
    assign err_sum = {1'b0, err_cnt} + 9'(err_inc);

    always_ff @(posedge noc_clk) begin
        if (noc_rst) begin
            state_reg    <= S_IDLE;
            src_reg      <= '0;
            dst_reg      <= '0;
            body_cnt_reg <= '0;
            bad_reg      <= 1'b0;
            last_src_reg <= '0;
            pkt_done     <= 1'b0;
            pkt_ok_cnt   <= '0;
            err_cnt      <= '0;
            err_flags    <= '0;
        end else begin
            state_reg    <= state_next;
            src_reg      <= src_next;
            dst_reg      <= dst_next;
            body_cnt_reg <= body_cnt_next;
            bad_reg      <= bad_next;
            last_src_reg <= last_src_next;
            pkt_done     <= done_next;
            pkt_ok_cnt   <= pkt_ok_cnt + 16'(ok_inc);
            err_cnt      <= err_sum[8] ? 8'hFF : err_sum[7:0];
            err_flags    <= err_flags | flags_set;
        end
    end

    assign last_src_x = last_src_reg[IDW-1:YW];
    assign last_src_y = last_src_reg[YW-1:0];
endmodule

// File: tb/tb_noc_packet_sink.sv
// Directed, table-driven bench for noc_packet_sink (own ID (3,2), 11 body flits per packet).
`ifndef Noc_Data_Width
`define Noc_Data_Width 32
`endif
`ifndef Noc_Source_Point
`define Noc_Source_Point 8
`endif
`ifndef Noc_ID_X_Width
`define Noc_ID_X_Width 2
`endif
`ifndef Noc_ID_Y_Width
`define Noc_ID_Y_Width 2
`endif

module tb_noc_packet_sink;
    localparam int DW  = `Noc_Data_Width;
    localparam int SL  = `Noc_Source_Point;
    localparam int XW  = `Noc_ID_X_Width;
    localparam int YW  = `Noc_ID_Y_Width;
    localparam int IDW = XW + YW;
    localparam logic [XW-1:0] OWN_X = XW'(3);
    localparam logic [YW-1:0] OWN_Y = YW'(2);

    logic          noc_clk = 1'b0;
    logic          noc_rst = 1'b1;
    logic          pkt_done;
    logic [15:0]   pkt_ok_cnt;
    logic [7:0]    err_cnt;
    logic [5:0]    err_flags;
    logic [XW-1:0] last_src_x;
    logic [YW-1:0] last_src_y;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    bit ready_low_seen = 1'b0;

    noc_packet_sink_if #(.DATA_W(DW)) rx ();

    noc_packet_sink #(
        .X_ID(OWN_X), .Y_ID(OWN_Y), .DATA_W(DW), .SRC_LSB(SL), .EXP_BODY(11), .FIFO_DEPTH(4)
    ) dut (
        .noc_clk(noc_clk), .noc_rst(noc_rst), .rx(rx),
        .pkt_done(pkt_done), .pkt_ok_cnt(pkt_ok_cnt), .err_cnt(err_cnt),
        .err_flags(err_flags), .last_src_x(last_src_x), .last_src_y(last_src_y)
    );

    always #5 noc_clk = ~noc_clk;

    always @(negedge noc_clk) begin
        if (pkt_done === 1'b1) done_cnt++;
        if (!noc_rst && rx.receive_ready !== 1'b1) ready_low_seen = 1'b1;
    end

    typedef struct {
        logic [XW-1:0] sx; logic [YW-1:0] sy;
        logic [XW-1:0] dx; logic [YW-1:0] dy;
        int nbody; int zero_idx; logic single;
        logic [XW-1:0] tsx; logic [YW-1:0] tsy;
        int exp_ok; int exp_err; logic [5:0] exp_flags;
    } vec_t;
    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk(input logic [XW-1:0] sx, input logic [YW-1:0] sy,
                                         input logic [XW-1:0] dx, input logic [YW-1:0] dy);
        logic [DW-1:0] f;
        f = '0;
        f[SL +: IDW]     = {sx, sy};
        f[SL-IDW +: IDW] = {dx, dy};
        return f;
    endfunction

    // Called and returns on a negedge; valid stays high until the flit is taken.
    task automatic send_flit(input logic h, input logic t, input logic [DW-1:0] f);
        int guard;
        logic acc;
        guard = 0;
        acc = 1'b0;
        rx.receive_valid = 1'b1;
        rx.receive_is_header = h;
        rx.receive_is_tail = t;
        rx.receive_flit = f;
        while (!acc && guard < 200) begin
            acc = rx.receive_ready;
            @(posedge noc_clk);
            guard++;
            if (!acc) @(negedge noc_clk);
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL handshake_timeout: ready never high in %0d cycles", guard);
        end
        @(negedge noc_clk);
    endtask

    task automatic send_packet(input logic [XW-1:0] sx, input logic [YW-1:0] sy,
                               input logic [XW-1:0] dx, input logic [YW-1:0] dy,
                               input int nbody, input int zero_idx,
                               input logic [XW-1:0] tsx, input logic [YW-1:0] tsy);
        logic [DW-1:0] body;
        send_flit(1'b1, 1'b0, mk(sx, sy, dx, dy));
        for (int i = 0; i < nbody; i++) begin
            body = (i == zero_idx) ? '0 : '1;
            send_flit(1'b0, 1'b0, body);
        end
        send_flit(1'b0, 1'b1, mk(tsx, tsy, dx, dy));
    endtask

    task automatic idle(input int n);
        rx.receive_valid = 1'b0;
        rx.receive_is_header = 1'b0;
        rx.receive_is_tail = 1'b0;
        repeat (n) @(negedge noc_clk);
    endtask

    task automatic do_reset();
        rx.receive_valid = 1'b0;
        noc_rst = 1'b1;
        @(negedge noc_clk);
        noc_rst = 1'b0;
    endtask

    task automatic chk_status(input string tag, input int ok, input int err, input logic [5:0] fl);
        chk({tag, "_ok_cnt"}, 32'(pkt_ok_cnt), 32'(ok));
        chk({tag, "_err_cnt"}, 32'(err_cnt), 32'(err));
        chk({tag, "_err_flags"}, 32'(err_flags), 32'(fl));
    endtask

    initial begin
        int d0;
        rx.receive_valid = 1'b0;
        rx.receive_is_header = 1'b0;
        rx.receive_is_tail = 1'b0;
        rx.receive_flit = '0;

        // sx sy dx dy nbody zero single tsx tsy | ok err flags
        vecs[0] = '{2'd1, 2'd2, OWN_X, OWN_Y, 10, -1, 1'b0, 2'd1, 2'd2, 0, 1, 6'b010000};
        vecs[1] = '{2'd0, 2'd3, OWN_X, OWN_Y, 11,  4, 1'b0, 2'd0, 2'd3, 0, 2, 6'b011000};
        vecs[2] = '{2'd2, 2'd0, OWN_X, OWN_Y,  0, -1, 1'b1, 2'd2, 2'd0, 0, 3, 6'b011000};
        vecs[3] = '{2'd2, 2'd2, OWN_X, OWN_Y, 11, -1, 1'b0, 2'd2, 2'd2, 1, 3, 6'b011000};
        vecs[4] = '{2'd1, 2'd1, 2'd0,  2'd0,  11, -1, 1'b0, 2'd1, 2'd1, 1, 4, 6'b011010};
        vecs[5] = '{2'd3, 2'd3, OWN_X, OWN_Y, 11, -1, 1'b0, 2'd0, 2'd0, 1, 5, 6'b111010};

        @(negedge noc_clk);
        do_reset();
        chk("reset_ready", 32'(rx.receive_ready), 32'd1);
        chk("reset_pkt_done", 32'(pkt_done), 32'd0);
        chk("reset_last_src", 32'({last_src_x, last_src_y}), 32'd0);
        chk_status("reset", 0, 0, 6'b0);

        // Single good packet with pkt_done timing relative to the tail handshake.
        d0 = done_cnt;
        send_flit(1'b1, 1'b0, mk(2'd1, 2'd0, OWN_X, OWN_Y));
        for (int i = 0; i < 11; i++) send_flit(1'b0, 1'b0, '1);
        send_flit(1'b0, 1'b1, mk(2'd1, 2'd0, OWN_X, OWN_Y));
        rx.receive_valid = 1'b0;
`ifndef NOC_SINK_BACKPRESSURE_EN
        chk("t1_done_at_tail_edge", 32'(pkt_done), 32'd0);
        @(negedge noc_clk);
        chk("t1_done_next_edge", 32'(pkt_done), 32'd1);
        @(negedge noc_clk);
        chk("t1_done_cleared", 32'(pkt_done), 32'd0);
`endif
        idle(20);
        chk("t1_done_pulses", 32'(done_cnt - d0), 32'd1);
        chk("t1_last_src", 32'({last_src_x, last_src_y}), 32'({2'd1, 2'd0}));
        chk_status("t1", 1, 0, 6'b0);
        $display("t1 single packet: ok=%0d err=%0d flags=%b", pkt_ok_cnt, err_cnt, err_flags);

        // Eleven back-to-back packets.
        do_reset();
        ready_low_seen = 1'b0;
        d0 = done_cnt;
        for (int p = 0; p < 11; p++) send_packet(2'd2, 2'd1, OWN_X, OWN_Y, 11, -1, 2'd2, 2'd1);
        idle(20);
`ifndef NOC_SINK_BACKPRESSURE_EN
        chk("t2_ready_never_low", 32'(ready_low_seen), 32'd0);
`endif
        chk("t2_done_pulses", 32'(done_cnt - d0), 32'd11);
        chk("t2_last_src", 32'({last_src_x, last_src_y}), 32'({2'd2, 2'd1}));
        chk_status("t2", 11, 0, 6'b0);
        $display("t2 back-to-back: ok=%0d err=%0d pulses=%0d", pkt_ok_cnt, err_cnt, done_cnt - d0);

        // Table of single packets; status accumulates across rows.
        do_reset();
        for (int v = 0; v < 6; v++) begin
            d0 = done_cnt;
            if (vecs[v].single)
                send_flit(1'b1, 1'b1, mk(vecs[v].sx, vecs[v].sy, vecs[v].dx, vecs[v].dy));
            else
                send_packet(vecs[v].sx, vecs[v].sy, vecs[v].dx, vecs[v].dy,
                            vecs[v].nbody, vecs[v].zero_idx, vecs[v].tsx, vecs[v].tsy);
            idle(20);
            chk($sformatf("vec%0d_done_pulses", v), 32'(done_cnt - d0), 32'd1);
            chk($sformatf("vec%0d_last_src", v), 32'({last_src_x, last_src_y}),
                32'({vecs[v].sx, vecs[v].sy}));
            chk_status($sformatf("vec%0d", v), vecs[v].exp_ok, vecs[v].exp_err, vecs[v].exp_flags);
            $display("vec%0d: ok=%0d err=%0d flags=%b", v, pkt_ok_cnt, err_cnt, err_flags);
        end

        // Orphan body flit, then a well-formed packet addressed elsewhere.
        do_reset();
        send_flit(1'b0, 1'b0, '1);
        send_packet(2'd1, 2'd0, 2'd0, 2'd0, 11, -1, 2'd1, 2'd0);
        idle(20);
        chk_status("orphan", 0, 2, 6'b000011);
        $display("orphan+misroute: ok=%0d err=%0d flags=%b", pkt_ok_cnt, err_cnt, err_flags);

        // Header arriving mid-packet closes the old packet as bad.
        do_reset();
        d0 = done_cnt;
        send_flit(1'b1, 1'b0, mk(2'd2, 2'd0, OWN_X, OWN_Y));
        for (int i = 0; i < 3; i++) send_flit(1'b0, 1'b0, '1);
        send_packet(2'd2, 2'd0, OWN_X, OWN_Y, 11, -1, 2'd2, 2'd0);
        idle(20);
        chk("hdr_done_pulses", 32'(done_cnt - d0), 32'd2);
        chk_status("hdr", 1, 1, 6'b000100);
        $display("header mid-packet: ok=%0d err=%0d flags=%b", pkt_ok_cnt, err_cnt, err_flags);

        // Four packets with valid held high; with stalls enabled the FIFO must fill.
        do_reset();
        ready_low_seen = 1'b0;
        d0 = done_cnt;
        for (int p = 0; p < 4; p++) send_packet(2'd1, 2'd3, OWN_X, OWN_Y, 11, -1, 2'd1, 2'd3);
        idle(30);
`ifdef NOC_SINK_BACKPRESSURE_EN
        chk("bp_ready_low_seen", 32'(ready_low_seen), 32'd1);
`endif
        chk("bp_done_pulses", 32'(done_cnt - d0), 32'd4);
        chk_status("bp", 4, 0, 6'b0);
        $display("four packets: ok=%0d err=%0d pulses=%0d", pkt_ok_cnt, err_cnt, done_cnt - d0);

        // Reset mid-packet discards the partial packet without counting an error.
        send_flit(1'b1, 1'b0, mk(2'd0, 2'd1, OWN_X, OWN_Y));
        for (int i = 0; i < 3; i++) send_flit(1'b0, 1'b0, '1);
        do_reset();
        chk("midrst_ready", 32'(rx.receive_ready), 32'd1);
        chk("midrst_pkt_done", 32'(pkt_done), 32'd0);
        chk("midrst_last_src", 32'({last_src_x, last_src_y}), 32'd0);
        chk_status("midrst", 0, 0, 6'b0);
        send_packet(2'd2, 2'd1, OWN_X, OWN_Y, 11, -1, 2'd2, 2'd1);
        idle(20);
        chk_status("postrst", 1, 0, 6'b0);
        $display("reset mid-packet then packet: ok=%0d err=%0d flags=%b", pkt_ok_cnt, err_cnt, err_flags);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
